// File: rtl/uart_receiver_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART definitions for the receiver (and the matching
//             transmitter): frame constants, receiver state encoding and the
//             parity helper used on both ends of the link.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int   UART_DATA_BITS = 8;
   localparam logic UART_IDLE_LVL  = 1'b1;
   localparam logic UART_START_LVL = 1'b0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } rx_state_t;

   // Even-XOR parity when enabled, otherwise the parity slot is a fixed mark.
   function automatic logic uart_parity(input logic                      pbit_ena,
                                        input logic [UART_DATA_BITS-1:0] data);
      return pbit_ena ? ^data : 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_receiver_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_receiver_fsm_if
//  Purpose  : Bundle of the receiver's control, serial line and result signals.
//  Ports    : ena, PbitEna, Rxin          - driven by the master (system side)
//             RxData, RxValid, ParityErr,
//             FrameErr, Rxo               - driven by the slave (receiver)
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_receiver_fsm_if;
   import uart_pkg::*;

   logic                      ena;
   logic                      PbitEna;
   logic                      Rxin;
   logic [UART_DATA_BITS-1:0] RxData;
   logic                      RxValid;
   logic                      ParityErr;
   logic                      FrameErr;
   logic                      Rxo;

   modport master (
      output ena, PbitEna, Rxin,
      input  RxData, RxValid, ParityErr, FrameErr, Rxo
   );

   modport slave (
      input  ena, PbitEna, Rxin,
      output RxData, RxValid, ParityErr, FrameErr, Rxo
   );

endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sync
//  Purpose  : Two-flop synchronizer for the asynchronous serial line, with an
//             optional 2-of-3 majority voter over consecutive synchronized
//             samples (macro UART_RX_MAJORITY_EN).
//  Ports    : clk, rst_n  - clock, asynchronous active-low reset
//             i_rxin      - raw serial line
//             o_rx_s      - synchronized line (2-clk latency)
//             o_rx_bit    - bit decision value: o_rx_s, or the vote of the
//                           current and two previous o_rx_s samples
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic i_rxin,
   output logic      o_rx_s,
   output logic      o_rx_bit
);

   logic r_meta;
   logic r_sync;

   // Flops reset to the idle (mark) level so reset never looks like a start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_rxin;
         r_sync <= r_meta;
      end
   end

   assign o_rx_s = r_sync;

`ifdef UART_RX_MAJORITY_EN
   logic r_d1;
   logic r_d2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d1 <= 1'b1;
         r_d2 <= 1'b1;
      end else begin
         r_d1 <= r_sync;
         r_d2 <= r_d1;
      end
   end

   // Vote over the samples at now, now-1 and now-2: a decision taken at
   // tick mid+1 covers ticks mid-1..mid+1.
   assign o_rx_bit = (r_sync & r_d1) | (r_sync & r_d2) | (r_d1 & r_d2);
`else
   assign o_rx_bit = r_sync;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_receiver_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : uart_receiver_fsm
//  Purpose  : Oversampling UART receiver: start, 8 data bits LSB first, one
//             parity bit, STOP_BITS_CHECKED stop bits. Delivers the byte with a
//             one-clk valid strobe, parity/frame error flags and a one-clk
//             resync pulse (Rxo) for the transmitter on any error.
//  Config   : UART_RX_MAJORITY_EN - 2-of-3 majority bit decisions.
//  Ports    : clk    - system clock
//             rst_n  - asynchronous active-low reset
//             bus    - uart_receiver_fsm_if.slave
//                      (ena, PbitEna, Rxin in; RxData, RxValid, ParityErr,
//                       FrameErr, Rxo out)
//  Revision : 1.0 - initial release
// ============================================================================
module uart_receiver_fsm
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT      = 16,
   parameter int STOP_BITS_CHECKED = 1
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   uart_receiver_fsm_if.slave   bus
);

   localparam int c_TICK_W = $clog2(CLKS_PER_BIT);
   localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(CLKS_PER_BIT - 1);
   localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
   localparam logic [2:0]          c_STOP_LAST = 3'(STOP_BITS_CHECKED - 1);
   localparam logic [2:0]          c_BIT_LAST  = 3'(UART_DATA_BITS - 1);

   // The voted build decides one clk after the mid-bit sample. Only the start
   // decision moves; the START->DATA transition then lands one clk later, so
   // every following decision at CLKS_PER_BIT-1 is again one clk after the
   // true mid-bit and the bit period stays aligned.
`ifdef UART_RX_MAJORITY_EN
   localparam logic [c_TICK_W-1:0] c_TICK_START = c_TICK_W'(CLKS_PER_BIT / 2);
`else
   localparam logic [c_TICK_W-1:0] c_TICK_START = c_TICK_W'(CLKS_PER_BIT / 2 - 1);
`endif

   rx_state_t                 r_state;
   rx_state_t                 w_state_nxt;
   logic [c_TICK_W-1:0]       r_tick;
   logic [2:0]                r_bit_idx;
   logic [2:0]                r_stop_cnt;
   logic [UART_DATA_BITS-1:0] r_shift;
   logic                      r_par_bad;
   logic                      r_frm_bad;
   logic                      r_wait_high;

   logic                      w_rx_s;
   logic                      w_bit;
   logic                      w_sample;
   logic                      w_par_bad_nxt;
   logic                      w_frm_bad_nxt;
   logic                      w_enter_done;

   logic [UART_DATA_BITS-1:0] r_rx_data;
   logic                      r_rx_valid;
   logic                      r_parity_err;
   logic                      r_frame_err;
   logic                      r_rxo;

   uart_rx_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_rxin   (bus.Rxin),
      .o_rx_s   (w_rx_s),
      .o_rx_bit (w_bit)
   );

   // ------------------------------------------------------------------ state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // ------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      if (!bus.ena) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               // After a framing error the line must go idle before re-arming.
               if (!r_wait_high && (w_rx_s == UART_START_LVL))
                  w_state_nxt = START;
            end
            START: begin
               if (r_tick == c_TICK_START)
                  w_state_nxt = (w_bit == UART_START_LVL) ? DATA : IDLE;
            end
            DATA: begin
               if ((r_tick == c_TICK_LAST) && (r_bit_idx == c_BIT_LAST))
                  w_state_nxt = PARITY;
            end
            PARITY: begin
               if (r_tick == c_TICK_LAST)
                  w_state_nxt = STOP;
            end
            STOP: begin
               if ((r_tick == c_TICK_LAST) && (r_stop_cnt == c_STOP_LAST))
                  w_state_nxt = DONE;
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // ----------------------------------------------------- output / flag comb
   always_comb begin
      w_sample      = (r_tick == c_TICK_LAST);
      w_par_bad_nxt = r_par_bad;
      w_frm_bad_nxt = r_frm_bad;
      if ((r_state == PARITY) && w_sample &&
          (w_bit != uart_parity(bus.PbitEna, r_shift)))
         w_par_bad_nxt = 1'b1;
      if ((r_state == STOP) && w_sample && (w_bit != UART_IDLE_LVL))
         w_frm_bad_nxt = 1'b1;
      // Only STOP leads to DONE and ena low forces IDLE, so this is the
      // single clk on which a completed frame is published.
      w_enter_done  = (w_state_nxt == DONE);
   end

   // --------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick      <= '0;
         r_bit_idx   <= '0;
         r_stop_cnt  <= '0;
         r_shift     <= '0;
         r_par_bad   <= 1'b0;
         r_frm_bad   <= 1'b0;
         r_wait_high <= 1'b0;
      end else begin
         if ((w_state_nxt != r_state) || (r_state == IDLE) || (r_tick == c_TICK_LAST))
            r_tick <= '0;
         else
            r_tick <= r_tick + c_TICK_ONE;

         if (r_state != DATA)
            r_bit_idx <= '0;
         else if (w_sample)
            r_bit_idx <= r_bit_idx + 3'd1;

         if ((r_state == DATA) && w_sample)
            r_shift[r_bit_idx] <= w_bit;

         if (r_state != STOP)
            r_stop_cnt <= '0;
         else if (w_sample)
            r_stop_cnt <= r_stop_cnt + 3'd1;

         if (!bus.ena || (r_state == IDLE)) begin
            r_par_bad <= 1'b0;
            r_frm_bad <= 1'b0;
         end else begin
            r_par_bad <= w_par_bad_nxt;
            r_frm_bad <= w_frm_bad_nxt;
         end

         if (w_enter_done && w_frm_bad_nxt)
            r_wait_high <= 1'b1;
         else if ((r_state == IDLE) && (w_rx_s == UART_IDLE_LVL))
            r_wait_high <= 1'b0;
      end
   end

   // -------------------------------------------------------- registered outs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
         r_rxo        <= 1'b0;
      end else begin
         r_rx_valid <= w_enter_done;
         r_rxo      <= w_enter_done & (w_par_bad_nxt | w_frm_bad_nxt);
         if (w_enter_done) begin
            r_rx_data    <= r_shift;
            r_parity_err <= w_par_bad_nxt;
            r_frame_err  <= w_frm_bad_nxt;
         end
      end
   end

   assign bus.RxData    = r_rx_data;
   assign bus.RxValid   = r_rx_valid;
   assign bus.ParityErr = r_parity_err;
   assign bus.FrameErr  = r_frame_err;
   assign bus.Rxo       = r_rxo;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_receiver_fsm
//  Purpose  : Self-checking bench for uart_receiver_fsm (CLKS_PER_BIT=16,
//             one stop bit). Stimulus pushes expected frames into a queue;
//             a monitor pops and compares on every RxValid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver_fsm;
   import uart_pkg::*;

   localparam int c_CPB = 16;

   logic clk;
   logic rst_n;

   uart_receiver_fsm_if bus ();

   uart_receiver_fsm #(
      .CLKS_PER_BIT      (c_CPB),
      .STOP_BITS_CHECKED (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic r_prev_valid = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   always @(negedge clk) begin
      exp_t e;
      if (bus.RxValid) begin
         chk("valid_one_clk", {31'd0, r_prev_valid}, 32'd0);
         if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_valid: got RxData %0h with no frame expected at %0t",
                     bus.RxData, $time);
         end else begin
            e = q.pop_front();
            chk("RxData",    {24'd0, bus.RxData},   {24'd0, e.d});
            chk("ParityErr", {31'd0, bus.ParityErr}, {31'd0, e.pe});
            chk("FrameErr",  {31'd0, bus.FrameErr},  {31'd0, e.fe});
            chk("Rxo",       {31'd0, bus.Rxo},       {31'd0, e.pe | e.fe});
         end
      end else if (bus.Rxo) begin
         n_cmp++;
         n_err++;
         $display("FAIL rxo_without_valid: got Rxo 1 expected 0 at %0t", $time);
      end
      r_prev_valid <= bus.RxValid;
   end

   // --------------------------------------------------------------- stimulus
   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_frame(input logic [7:0] d, input logic pe, input logic fe);
      exp_t e;
      e.d  = d;
      e.pe = pe;
      e.fe = fe;
      q.push_back(e);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_RxData"},    {24'd0, bus.RxData},   32'd0);
      chk({tag, "_RxValid"},   {31'd0, bus.RxValid},  32'd0);
      chk({tag, "_ParityErr"}, {31'd0, bus.ParityErr}, 32'd0);
      chk({tag, "_FrameErr"},  {31'd0, bus.FrameErr},  32'd0);
      chk({tag, "_Rxo"},       {31'd0, bus.Rxo},       32'd0);
   endtask

   // Drives one frame. ena_off_bit / rst_bit (0..7, or -1 for none) drop ena
   // or assert reset during that data bit; both are restored after the frame.
   // tail_low holds the line low for that many bit periods after the stop bit.
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                             input int tail_low, input int ena_off_bit, input int rst_bit);
      bus.Rxin = 1'b0;
      wait_clks(c_CPB);
      for (int i = 0; i < 8; i++) begin
         bus.Rxin = d[i];
         if (i == ena_off_bit) bus.ena = 1'b0;
         if (i == rst_bit) begin
            wait_clks(c_CPB / 2);
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midframe_rst");
            wait_clks(c_CPB / 2);
         end else begin
            wait_clks(c_CPB);
         end
      end
      bus.Rxin = par;
      wait_clks(c_CPB);
      bus.Rxin = stp;
      wait_clks(c_CPB);
      if (tail_low > 0) begin
         bus.Rxin = 1'b0;
         wait_clks(tail_low * c_CPB);
      end
      bus.Rxin = 1'b1;
      wait_clks(2 * c_CPB);
      bus.ena = 1'b1;
      rst_n   = 1'b1;
      wait_clks(c_CPB);
   endtask

   initial begin
      int budget;
      rst_n       = 1'b0;
      bus.ena     = 1'b1;
      bus.PbitEna = 1'b1;
      bus.Rxin    = 1'b1;
      wait_clks(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      wait_clks(c_CPB);

      // Good frame: 0xA5 has four ones -> even parity bit 0.
      expect_frame(8'hA5, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b0, 1'b1, 0, -1, -1);

      // Parity disabled: parity slot must be 1.
      bus.PbitEna = 1'b0;
      expect_frame(8'h3C, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b1, 0, -1, -1);
      expect_frame(8'h3C, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b1, 0, -1, -1);

      // Parity error: 0x01 needs parity 1, send 0.
      bus.PbitEna = 1'b1;
      expect_frame(8'h01, 1'b1, 1'b0);
      send_frame(8'h01, 1'b0, 1'b1, 0, -1, -1);

      // Frame error with the line stuck low for three bit times afterwards.
      expect_frame(8'h55, 1'b0, 1'b1);
      send_frame(8'h55, 1'b0, 1'b0, 3, -1, -1);
      chk("frameerr_held", {31'd0, bus.FrameErr}, 32'd1);
      chk("paritydrr_held_clear", {31'd0, bus.ParityErr}, 32'd0);

      // 4-clk glitch: false start, nothing delivered.
      bus.Rxin = 1'b0;
      wait_clks(4);
      bus.Rxin = 1'b1;
      wait_clks(3 * c_CPB);
      chk("glitch_no_valid_pending", q.size(), 32'd0);

      // Abort via ena at data bit 4, then a full frame 0x81 (parity 0).
      send_frame(8'h99, 1'b0, 1'b1, 0, 4, -1);
      expect_frame(8'h81, 1'b0, 1'b0);
      send_frame(8'h81, 1'b0, 1'b1, 0, -1, -1);
      chk("abort_last_data_held", {24'd0, bus.RxData}, 32'h81);

      // Reset during bit 5 of 0xFF, then 0x0F (parity 0).
      send_frame(8'hFF, 1'b0, 1'b1, 0, -1, 5);
      expect_frame(8'h0F, 1'b0, 1'b0);
      send_frame(8'h0F, 1'b0, 1'b1, 0, -1, -1);

      budget = 0;
      while ((q.size() != 0) && (budget < 4 * c_CPB)) begin
         wait_clks(1);
         budget++;
      end
      chk("queue_drained", q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
